// File: rtl/spi_ht16d35a_pkg.sv
// Shared types, default timing and bit-order helper for the
// HT16D35A-style receive-only SPI peripheral.
package spi_ht16d35a_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RX_BITS,
      S_GAP
   } state_t;

   localparam int CLK_HZ_DEF      = 50_000_000;
   localparam int CLK_2US_DEF     = 100;
   localparam int SYNC_STAGES_DEF = 2;

   // Shift one received bit into the assembly register.
   // MSB-first shifts left; LSB-first shifts right so the
   // first bit lands in bit 0 after eight shifts.
   function automatic logic [7:0] shift_in(
      input logic [7:0] sr,
      input logic       b,
      input logic       lsb_first
   );
      if (lsb_first) begin
         return {b, sr[7:1]};
      end
      return {sr[6:0], b};
   endfunction

endpackage

// File: rtl/spi_peripheral_ht16d35a_rx_sync.sv
// Multi-flop synchronizer with history flop and edge detect.
// Ports: clk_i, reset_ni, d_i (async) -> q_o, rise_o, fall_o.
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              hist_q;

   assign sync_d = {sync_q[STAGES-2:0], d_i};

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         sync_q <= {STAGES{RST_VAL}};
         hist_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         hist_q <= sync_q[STAGES-1];
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_o = sync_q[STAGES-1] & ~hist_q;
   assign fall_o = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_peripheral_ht16d35a_rx.sv
// Receive-only 3-wire SPI peripheral: oversampled bus, byte strobe,
// frame buffer and framing-error flags.
// Ports: clk, reset_n, sck/dio/cs (async bus) -> busy, byte_valid,
// byte_data, byte_index, frame_done, out_data[], out_count, err_*.
module spi_peripheral_ht16d35a_rx
   import spi_ht16d35a_pkg::*;
#(
   parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
   parameter int CLK_2us      = CLK_2US_DEF,
   parameter int MAX_BYTES    = 8,
   parameter int MAX_BYTES_SZ = $clog2(MAX_BYTES + 1),
   parameter int LSB_FIRST    = 0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    sck,
   input  logic                    dio,
   input  logic                    cs,
   output logic                    busy,
   output logic                    byte_valid,
   output logic [7:0]              byte_data,
   output logic [MAX_BYTES_SZ-1:0] byte_index,
   output logic                    frame_done,
   output logic [7:0]              out_data [MAX_BYTES],
   output logic [MAX_BYTES_SZ-1:0] out_count,
   output logic                    err_partial,
   output logic                    err_gap,
   output logic                    err_overflow
);

   localparam int GW = $clog2(CLK_2us + 1);
   localparam int AW = $clog2(SYNC_STAGES + 2);
   localparam logic [GW-1:0] GAP_MAX = GW'(CLK_2us);
   localparam logic [MAX_BYTES_SZ-1:0] MAX_CNT = MAX_BYTES_SZ'(MAX_BYTES);
   localparam logic [AW-1:0] ARM_MAX = AW'(SYNC_STAGES + 1);

   logic sck_s, sck_rise, sck_fall;
   logic cs_s, cs_rise, cs_fall;
   logic dio_s, dio_rise, dio_fall;
   logic unused_dio_edges;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sck (
      .clk_i   (clk),
      .reset_ni(reset_n),
      .d_i     (sck),
      .q_o     (sck_s),
      .rise_o  (sck_rise),
      .fall_o  (sck_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
      .clk_i   (clk),
      .reset_ni(reset_n),
      .d_i     (cs),
      .q_o     (cs_s),
      .rise_o  (cs_rise),
      .fall_o  (cs_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dio (
      .clk_i   (clk),
      .reset_ni(reset_n),
      .d_i     (dio),
      .q_o     (dio_s),
      .rise_o  (dio_rise),
      .fall_o  (dio_fall)
   );

   assign unused_dio_edges = dio_rise ^ dio_fall;

   state_t                  state_q, state_d;
   logic [3:0]              bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
   logic [7:0]              shift_q, shift_d, shift_nx;
   logic [MAX_BYTES_SZ-1:0] count_q, count_d;
   logic                    bv_q, bv_d;
   logic [7:0]              bdata_q, bdata_d;
   logic [MAX_BYTES_SZ-1:0] bidx_q, bidx_d;
   logic                    fd_q, fd_d;
   logic                    ep_q, ep_d;
   logic                    eg_q, eg_d;
   logic                    eo_q, eo_d;
   logic                    armed_q, armed_d;
   logic [AW-1:0]           arm_cnt_q, arm_cnt_d;
   logic                    wr_en;
   logic [7:0]              mem_q [MAX_BYTES];

   assign shift_nx = shift_in(shift_q, dio_s, LSB_FIRST != 0);

   // After reset the synchronizer holds a fake "high"; cs must be
   // really observed high through the whole chain before a fall
   // may open a frame.
   always_comb begin
      armed_d   = armed_q;
      arm_cnt_d = arm_cnt_q;
      if (!armed_q) begin
         if (!cs_s) begin
            arm_cnt_d = '0;
         end else if (arm_cnt_q == ARM_MAX) begin
            armed_d = 1'b1;
         end else begin
            arm_cnt_d = arm_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      shift_d   = shift_q;
      count_d   = count_q;
      bv_d      = 1'b0;
      bdata_d   = bdata_q;
      bidx_d    = bidx_q;
      fd_d      = 1'b0;
      ep_d      = ep_q;
      eg_d      = eg_q;
      eo_d      = eo_q;
      wr_en     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cs_fall && armed_q) begin
               count_d   = '0;
               bit_cnt_d = '0;
               gap_cnt_d = '0;
               ep_d      = 1'b0;
               eg_d      = 1'b0;
               eo_d      = 1'b0;
               state_d   = S_RX_BITS;
            end
         end
         S_RX_BITS: begin
            // cs release wins over a same-cycle sck rise
            if (cs_rise) begin
               if (bit_cnt_q != '0) ep_d = 1'b1;
               fd_d    = 1'b1;
               state_d = S_IDLE;
            end else if (sck_rise) begin
               shift_d   = shift_nx;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 4'd7) begin
                  if (count_q < MAX_CNT) begin
                     wr_en   = 1'b1;
                     bv_d    = 1'b1;
                     bdata_d = shift_nx;
                     bidx_d  = count_q;
                     count_d = count_q + 1'b1;
                  end else begin
                     eo_d = 1'b1;
                  end
                  gap_cnt_d = '0;
                  state_d   = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (sck_s && gap_cnt_q < GAP_MAX) begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
            if (cs_rise) begin
               if (gap_cnt_q < GAP_MAX) eg_d = 1'b1;
               fd_d    = 1'b1;
               state_d = S_IDLE;
            end else if (sck_fall) begin
               if (gap_cnt_q < GAP_MAX) eg_d = 1'b1;
               bit_cnt_d = '0;
               state_d   = S_RX_BITS;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         shift_q   <= '0;
         count_q   <= '0;
         bv_q      <= 1'b0;
         bdata_q   <= '0;
         bidx_q    <= '0;
         fd_q      <= 1'b0;
         ep_q      <= 1'b0;
         eg_q      <= 1'b0;
         eo_q      <= 1'b0;
         armed_q   <= 1'b0;
         arm_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         shift_q   <= shift_d;
         count_q   <= count_d;
         bv_q      <= bv_d;
         bdata_q   <= bdata_d;
         bidx_q    <= bidx_d;
         fd_q      <= fd_d;
         ep_q      <= ep_d;
         eg_q      <= eg_d;
         eo_q      <= eo_d;
         armed_q   <= armed_d;
         arm_cnt_q <= arm_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < MAX_BYTES; i++) mem_q[i] <= '0;
      end else begin
         for (int i = 0; i < MAX_BYTES; i++) begin
            if (wr_en && count_q == MAX_BYTES_SZ'(i)) begin
               mem_q[i] <= shift_nx;
            end
         end
      end
   end

   assign busy         = ~cs_s;
   assign byte_valid   = bv_q;
   assign byte_data    = bdata_q;
   assign byte_index   = bidx_q;
   assign frame_done   = fd_q;
   assign out_data     = mem_q;
   assign out_count    = count_q;
   assign err_partial  = ep_q;
   assign err_gap      = eg_q;
   assign err_overflow = eo_q;

endmodule
